// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate 4-line x 4-word x 16-bit data cache.
// Defining DATA_CACHE_STATS_EN adds wrap-around hitCount/missCount outputs.
module data_cache #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        d_readM,
  input  logic        d_writeM,
  input  logic [15:0] d_address,
  inout  wire  [15:0] d_data,
  output logic        cacheStall,
  output logic        m_readM,
  output logic        m_writeM,
  output logic [15:0] m_address,
  inout  wire  [15:0] m_data
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [15:0] hitCount,
  output logic [15:0] missCount
`endif
);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [1:0] r_word;
  logic [3:0] r_valid;
  logic [11:0] r_tag [4];
  logic [15:0] r_data [4][4];
  logic [15:0] r_addr, r_wdata;
  logic w_hit, w_rd_hit, w_last, w_wr_hit;
  assign w_hit    = r_valid[d_address[3:2]] && r_tag[d_address[3:2]] == d_address[15:4];
  assign w_rd_hit = r_state == IDLE && d_readM && !d_writeM && w_hit;
  assign w_last   = r_cnt == 4'(MEM_LATENCY - 1);
  assign w_wr_hit = r_valid[r_addr[3:2]] && r_tag[r_addr[3:2]] == r_addr[15:4];
  assign d_data   = w_rd_hit ? r_data[d_address[3:2]][d_address[1:0]] : 'z;
  assign m_data   = m_writeM ? r_wdata : 'z;
  always_comb begin
    w_next     = r_state;
    cacheStall = 1'b0;
    m_readM    = 1'b0;
    m_writeM   = 1'b0;
    m_address  = r_addr;
    case (r_state)
      IDLE: begin
        cacheStall = d_writeM || (d_readM && !w_hit);
        w_next     = d_writeM ? WRITE : (d_readM && !w_hit) ? FILL : IDLE;
      end
      FILL: begin
        cacheStall = 1'b1;
        m_readM    = 1'b1;
        m_address  = {r_addr[15:2], r_word};
        w_next     = (w_last && r_word == 2'd3) ? IDLE : FILL;
      end
      WRITE: begin
        cacheStall = 1'b1;
        m_writeM   = 1'b1;
        w_next     = w_last ? DONE : WRITE;
      end
      DONE: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) r_addr <= d_address;
      if (r_state == IDLE && d_writeM) r_wdata <= d_data;
      if (r_state == FILL || r_state == WRITE) r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
      if (r_state == FILL && w_last) begin
        r_data[r_addr[3:2]][r_word] <= m_data;
        r_word <= r_word + 2'd1;
        if (r_word == 2'd3) begin
          r_valid[r_addr[3:2]] <= 1'b1;
          r_tag[r_addr[3:2]]   <= r_addr[15:4];
        end
      end
      // write-through keeps the line coherent only on a hit; misses never allocate
      if (r_state == WRITE && w_last && w_wr_hit) r_data[r_addr[3:2]][r_addr[1:0]] <= r_wdata;
    end
  end
`ifdef DATA_CACHE_STATS_EN
  logic r_post_fill;
  always_ff @(posedge Clk) begin
    if (Reset_N) begin
      hitCount    <= '0;
      missCount   <= '0;
      r_post_fill <= 1'b0;
    end else begin
      r_post_fill <= r_state == FILL && w_next == IDLE;
      if (r_state == IDLE && w_next == FILL) missCount <= missCount + 16'd1;
      if (w_rd_hit && !r_post_fill) hitCount <= hitCount + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed table plus randomized traffic against a line-residency reference model.
`timescale 1ns/1ps
module tb_data_cache;
  localparam int L = 2;
  logic Clk = 0, Reset_N = 1, d_readM = 0, d_writeM = 0;
  logic [15:0] d_address = 0;
  wire [15:0] d_data, m_data;
  logic cacheStall, m_readM, m_writeM;
  logic [15:0] m_address;
  logic tb_drv = 0;
  logic [15:0] tb_wdata = 0;
  logic [15:0] mem [65536];
  logic mem_ready = 0;
  logic [15:0] ref_mem [65536];
  logic [3:0] ref_valid = 0;
  logic [11:0] ref_tag [4];
  int ref_hits = 0, ref_misses = 0;
  int errors = 0, checks = 0;
`ifdef DATA_CACHE_STATS_EN
  logic [15:0] hitCount, missCount;
`endif

  data_cache #(.MEM_LATENCY(L)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .d_readM(d_readM), .d_writeM(d_writeM),
    .d_address(d_address), .d_data(d_data), .cacheStall(cacheStall),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_data(m_data)
`ifdef DATA_CACHE_STATS_EN
    , .hitCount(hitCount), .missCount(missCount)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0013) ? 16'hBEEF : (a ^ 16'h5A00);
  endfunction

  assign d_data = tb_drv ? tb_wdata : 'z;
  assign m_data = m_readM ? mem[m_address] : 'z;

  always @(posedge Clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
      mem_ready <= 1;
    end else if (m_writeM) mem[m_address] <= m_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // op: 0 read, 1 write, 2 read+write together (handled as write)
  task automatic do_op(input int op, input logic [15:0] a, input logic [15:0] wd,
                       input int exp_stall, input logic [15:0] exp_rd);
    int st, wcnt, rcnt, bad;
    @(posedge Clk); #1;
    d_address = a; d_readM = (op != 1); d_writeM = (op != 0); tb_drv = (op != 0); tb_wdata = wd;
    st = 0; wcnt = 0; rcnt = 0; bad = 0;
    @(negedge Clk);
    while (cacheStall && st < 200) begin
      if (m_readM) begin
        rcnt++;
        if (st < 1 || m_address !== {a[15:2], 2'((st - 1) / L)}) bad++;
      end
      if (m_writeM) begin
        wcnt++;
        if (m_address !== a || m_data !== wd) bad++;
      end
      st++;
      @(negedge Clk);
    end
    chk($sformatf("stall@%h", a), 32'(st), 32'(exp_stall));
    chk($sformatf("bus@%h", a), 32'(bad), 0);
    if (op == 0) begin
      chk($sformatf("rdata@%h", a), {16'h0, d_data}, {16'h0, exp_rd});
      chk($sformatf("rd_cycles@%h", a), 32'(rcnt), 32'(exp_stall == 0 ? 0 : 4 * L));
      chk($sformatf("no_wr@%h", a), 32'(wcnt), 0);
    end else begin
      chk($sformatf("wr_cycles@%h", a), 32'(wcnt), 32'(L));
      chk($sformatf("no_rd@%h", a), 32'(rcnt), 0);
    end
    @(posedge Clk); #1;
    d_readM = 0; d_writeM = 0; tb_drv = 0;
  endtask

  task automatic model_op(input int op, input logic [15:0] a, input logic [15:0] wd);
    logic hit;
    hit = ref_valid[a[3:2]] && ref_tag[a[3:2]] == a[15:4];
    if (op == 0) begin
      do_op(0, a, 16'h0, hit ? 0 : 1 + 4 * L, ref_mem[a]);
      if (hit) ref_hits++; else ref_misses++;
      ref_valid[a[3:2]] = 1;
      ref_tag[a[3:2]] = a[15:4];
    end else begin
      do_op(op, a, wd, 1 + L, 16'h0);
      ref_mem[a] = wd;
    end
  endtask

  typedef struct {
    int op;
    logic [15:0] a;
    logic [15:0] wd;
    int st;
    logic [15:0] rd;
  } vec_t;
  vec_t tv [11];

  initial begin
    int n;
    logic [15:0] ra;
    int rop;
    tv[0]  = '{0, 16'h0013, 16'h0000, 1 + 4 * L, 16'hBEEF};
    tv[1]  = '{0, 16'h0011, 16'h0000, 0,         16'h5A11};
    tv[2]  = '{1, 16'h0012, 16'h1234, 1 + L,     16'h0000};
    tv[3]  = '{0, 16'h0012, 16'h0000, 0,         16'h1234};
    tv[4]  = '{0, 16'h0053, 16'h0000, 1 + 4 * L, 16'h5A53};
    tv[5]  = '{0, 16'h0013, 16'h0000, 1 + 4 * L, 16'hBEEF};
    tv[6]  = '{2, 16'h0020, 16'hCAFE, 1 + L,     16'h0000};
    tv[7]  = '{1, 16'h0031, 16'h7777, 1 + L,     16'h0000};
    tv[8]  = '{0, 16'h0013, 16'h0000, 0,         16'hBEEF};
    tv[9]  = '{0, 16'h0031, 16'h0000, 1 + 4 * L, 16'h7777};
    tv[10] = '{0, 16'h0020, 16'h0000, 1 + 4 * L, 16'hCAFE};
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_stall", 32'(cacheStall), 0);
    chk("rst_mrd", 32'(m_readM), 0);
    chk("rst_mwr", 32'(m_writeM), 0);
    Reset_N = 0;
    @(negedge Clk);
    chk("idle_stall", 32'(cacheStall), 0);
    chk("idle_mrd", 32'(m_readM), 0);
    chk("idle_mwr", 32'(m_writeM), 0);

    for (int i = 0; i < 11; i++) begin
      do_op(tv[i].op, tv[i].a, tv[i].wd, tv[i].st, tv[i].rd);
      if (tv[i].op != 0) ref_mem[tv[i].a] = tv[i].wd;
`ifdef DATA_CACHE_STATS_EN
      if (i == 5) begin
        chk("missCount", 32'(missCount), 3);
        chk("hitCount", 32'(hitCount), 2);
      end
      if (i == 6) chk("missCount_rw", 32'(missCount), 3);
`endif
    end

    // abort a fill during word 2, then the same read must take the full miss
    @(posedge Clk); #1;
    d_address = 16'h0073; d_readM = 1;
    n = 0;
    while (!(m_readM && m_address == 16'h0072) && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("reach_word2", 32'(n < 50), 1);
    Reset_N = 1; d_readM = 0;
    @(posedge Clk); #1;
    chk("abort_mrd", 32'(m_readM), 0);
    chk("abort_stall", 32'(cacheStall), 0);
    Reset_N = 0;
    ref_valid = 0; ref_hits = 0; ref_misses = 0;
    do_op(0, 16'h0073, 16'h0, 1 + 4 * L, 16'h5A73);
    ref_misses = 1; ref_valid[0] = 1; ref_tag[0] = 12'h007;

    for (int k = 0; k < 300; k++) begin
      ra = 16'($urandom_range(0, 63));
      if ($urandom % 8 == 0) ra[15:12] = 4'hF;
      rop = $urandom % 4;
      model_op(rop < 2 ? 0 : rop - 1, ra, 16'($urandom));
    end
`ifdef DATA_CACHE_STATS_EN
    chk("final_hits", 32'(hitCount), 32'(ref_hits));
    chk("final_misses", 32'(missCount), 32'(ref_misses));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning the backing-memory cycles per word access (legal range 1..15).
REQ-002 SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_N, input, 1 bit: synchronous active-high reset; the name is kept for the codebase, but the polarity is high.
REQ-004 SHALL have port d_readM, input, 1 bit: CPU data-read request.
REQ-005 SHALL have port d_writeM, input, 1 bit: CPU data-write request.
REQ-006 SHALL have port d_address, input, 16 bits: CPU word address; tag [15:4], index [3:2], offset [1:0].
REQ-007 SHALL have port d_data, inout, 16 bits: driven by the cache on a read hit, otherwise 16'hzzzz; write data is sampled from it.
REQ-008 SHALL have port cacheStall, output, 1 bit: high means the CPU pipeline holds all registers this cycle.
REQ-009 SHALL have port m_readM, output, 1 bit: memory read strobe.
REQ-010 SHALL have port m_writeM, output, 1 bit: memory write strobe.
REQ-011 SHALL have port m_address, output, 16 bits: memory word address.
REQ-012 SHALL have port m_data, inout, 16 bits: the cache drives it only while m_writeM is high, otherwise 16'hzzzz.

Function
REQ-013 SHALL implement direct-mapped storage: 4 lines x 4 words x 16 bits, with a 12-bit tag and a valid bit per line.
REQ-014 SHALL use write-through, no-write-allocate policy.
REQ-015 SHALL have FSM states IDLE, FILL, WRITE, DONE.
REQ-016 SHALL, in IDLE with d_readM=1, d_writeM=0 and a hit (valid and tag match), combinationally drive d_data with the word and hold cacheStall=0, giving zero added latency.
REQ-017 SHALL, in IDLE on a read miss, drive cacheStall=1 combinationally in the same cycle and move to FILL at the next edge.
REQ-018 SHALL, in FILL:
  - fetch words 0..3 of the line in order;
  - hold each word for MEM_LATENCY cycles with m_readM=1 and m_address={tag,index,word};
  - capture m_data on the last cycle of each word;
  - keep cacheStall=1.
REQ-019 SHALL, after word 3, set the line's valid bit and tag and return to IDLE, where the pending read now hits; total stall on a read miss is 1+4*MEM_LATENCY cycles.
REQ-020 SHALL, in IDLE with d_writeM=1, drive cacheStall=1, latch d_address and d_data, and move to WRITE.
REQ-021 SHALL, in WRITE, hold m_writeM=1, m_address=latched address and m_data=latched data for MEM_LATENCY cycles, then move to DONE.
REQ-022 SHALL, on entering DONE, update the matching word if the line is valid and the tag matches (write hit); a write miss leaves the array unchanged.
REQ-023 SHALL, in DONE, hold cacheStall=0 for exactly one cycle and then return to IDLE, so the CPU retires the write exactly once; total write stall is 1+MEM_LATENCY cycles.
REQ-024 SHALL give d_writeM priority when d_readM and d_writeM are high together; the request is handled as a write only.
REQ-025 SHALL, with no request in IDLE, hold cacheStall=0, m_readM=0, m_writeM=0 and d_data high-impedance.
REQ-026 SHALL hold m_readM and m_writeM mutually exclusive in every cycle.

Reset
REQ-027 SHALL, with Reset_N=1 at a rising edge, set state=IDLE, clear all valid bits and all counters, and set cacheStall, m_readM and m_writeM to 0 from that edge.
REQ-028 SHALL, on reset during FILL or WRITE, abort the transfer, leave the partially filled line invalid, and not retry the transfer after reset.
REQ-029 SHALL leave data array contents unspecified after reset; only the valid bits are guaranteed cleared.

Configuration
REQ-030 SHALL, when macro DATA_CACHE_STATS_EN is defined, add 16-bit outputs hitCount and missCount, both wrap-around counters:
  - missCount increments on each IDLE->FILL transition;
  - hitCount increments on each IDLE read hit, except the one completing the read immediately after a FILL.
REQ-031 SHALL, when DATA_CACHE_STATS_EN is undefined, have neither port nor counters and otherwise behave identically.

Verification
REQ-032 SHALL cover: after reset, read 0x0013 with memory word 0x0013=0xBEEF -> cacheStall high 9 cycles, m_address steps 0x0010..0x0013 every 2 cycles, then d_data=0xBEEF with stall low.
REQ-033 SHALL cover: re-read 0x0011 -> 0 stall cycles, d_data equals memory word 0x0011.
REQ-034 SHALL cover: write 0x1234 to 0x0012 (hit) -> stall 3 cycles, m_writeM high 2 cycles with m_address=0x0012, DONE 1 cycle, then read 0x0012 returns 0x1234 with 0 stall.
REQ-035 SHALL cover: read 0x0053 (same index, tag 0x005) -> miss, line replaced; a following read 0x0013 misses again; with stats on, missCount=3 and hitCount=2.
REQ-036 SHALL cover: assert Reset_N during word 2 of a FILL -> m_readM=0 after the edge, and a following read of the same address takes the full 9-cycle miss.
REQ-037 SHALL cover: d_readM=d_writeM=1 at 0x0020 -> only m_writeM pulses, and missCount is unchanged.
